// File: rtl/snn_accel_pkg.sv
// snn_accel_pkg: shared widths, block indexing constants and the saturating adder
// used by the SNN accelerator datapath.
package snn_accel_pkg;
   localparam int ACCW_DEF  = 40;
   localparam int BLK_ROWS  = 4;
   localparam int BLK_COLS  = 4;
   localparam int BLK_ELEMS = BLK_ROWS * BLK_COLS;
   typedef struct packed {
      logic               ovf;
      logic signed [63:0] val;
   } sat_res_t;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
      return r;
   endfunction
   // Operands are carried at 64 bits, so w may be anything up to 63.
   function automatic sat_res_t sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
      logic signed [64:0] s, mx, mn;
      s = 65'(a) + 65'(b);
      mx = (65'sd1 <<< (w - 1)) - 65'sd1;
      mn = -(65'sd1 <<< (w - 1));
      sat_add.ovf = (s > mx) || (s < mn);
      sat_add.val = (s > mx) ? mx[63:0] : (s < mn) ? mn[63:0] : s[63:0];
   endfunction
endpackage

// File: rtl/snn_group_adder.sv
// snn_group_adder: sign-extends FANIN input blocks to ACCW and sums them element-wise
// into one registered block.
module snn_group_adder
   import snn_accel_pkg::*;
#(
   parameter int DATAWIDTH   = 32,
   parameter int BLOCK_ELEMS = BLK_ELEMS,
   parameter int FANIN       = 3,
   parameter int ACCW        = ACCW_DEF
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 i_en,
   input  logic [FANIN*BLOCK_ELEMS*DATAWIDTH-1:0] i_blocks,
   output logic [BLOCK_ELEMS*ACCW-1:0]          o_sum
);
   logic [BLOCK_ELEMS*ACCW-1:0] w_sum, r_sum;
   always_comb begin
      w_sum = '0;
      for (int e = 0; e < BLOCK_ELEMS; e++)
         for (int f = 0; f < FANIN; f++)
            w_sum[e*ACCW +: ACCW] = w_sum[e*ACCW +: ACCW]
               + ACCW'($signed(i_blocks[(f*BLOCK_ELEMS+e)*DATAWIDTH +: DATAWIDTH]));
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sum <= '0;
      else if (i_en) r_sum <= w_sum;
   end
   assign o_sum = r_sum;
endmodule

// File: rtl/snn_partial_sum_reducer.sv
// snn_partial_sum_reducer: per-group block reduction plus per-frame accumulation with a
// valid/ready result port and a registered readout. Define SNN_REDUCER_SAT_EN to clamp.
module snn_partial_sum_reducer
   import snn_accel_pkg::*;
#(
   parameter int DATAWIDTH   = 32,
   parameter int BLOCK_ELEMS = BLK_ELEMS,
   parameter int GROUPS      = 3,
   parameter int FANIN       = 3,
   parameter int ACCW        = ACCW_DEF,
   localparam int GW         = (GROUPS > 1) ? clog2(GROUPS) : 1
) (
   input  logic                                        clk,
   input  logic                                        rst_n,
   input  logic [GROUPS*FANIN*BLOCK_ELEMS*DATAWIDTH-1:0] in_data,
   input  logic                                        in_valid,
   input  logic                                        in_last,
   output logic                                        in_ready,
   output logic [GROUPS*BLOCK_ELEMS*ACCW-1:0]          out_data,
   output logic [15:0]                                 out_beats,
   output logic                                        out_ovf,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   input  logic [GW-1:0]                               rd_group,
   input  logic [3:0]                                  rd_elem,
   output logic [ACCW-1:0]                             rd_data
);
   localparam int OW = GROUPS * BLOCK_ELEMS * ACCW;
   localparam int GI = FANIN * BLOCK_ELEMS * DATAWIDTH;
   logic            w_stall, w_ovf_any, w_ovf_frame;
   logic            r_s1_valid, r_s1_last, r_first, r_out_valid, r_ovf, r_out_ovf;
   logic [15:0]     w_beats, r_beats, r_out_beats;
   logic [OW-1:0]   w_s1_sum, w_base, w_acc_next, r_acc, r_hold;
   logic [ACCW-1:0] r_rd;
`ifdef SNN_REDUCER_SAT_EN
   sat_res_t        w_sr [GROUPS*BLOCK_ELEMS];
`endif
   assign w_stall  = r_out_valid & ~out_ready;
   assign in_ready = ~w_stall;
   genvar g;
   generate
      for (g = 0; g < GROUPS; g++) begin : g_grp
         snn_group_adder #(
            .DATAWIDTH(DATAWIDTH), .BLOCK_ELEMS(BLOCK_ELEMS), .FANIN(FANIN), .ACCW(ACCW)
         ) u_add (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_en     (in_valid & ~w_stall),
            .i_blocks (in_data[g*GI +: GI]),
            .o_sum    (w_s1_sum[g*BLOCK_ELEMS*ACCW +: BLOCK_ELEMS*ACCW])
         );
      end
   endgenerate
   assign w_base = r_first ? '0 : r_acc;
   always_comb begin
      w_acc_next = '0;
      w_ovf_any  = 1'b0;
      for (int i = 0; i < GROUPS*BLOCK_ELEMS; i++) begin
`ifdef SNN_REDUCER_SAT_EN
         w_sr[i] = sat_add(64'($signed(w_base[i*ACCW +: ACCW])), 64'($signed(w_s1_sum[i*ACCW +: ACCW])), ACCW);
         w_acc_next[i*ACCW +: ACCW] = w_sr[i].val[ACCW-1:0];
         w_ovf_any = w_ovf_any | w_sr[i].ovf;
`else
         w_acc_next[i*ACCW +: ACCW] = w_base[i*ACCW +: ACCW] + w_s1_sum[i*ACCW +: ACCW];
`endif
      end
   end
   assign w_beats     = (r_beats == 16'hFFFF) ? r_beats : r_beats + 16'd1;
   assign w_ovf_frame = (~r_first & r_ovf) | w_ovf_any;
   // The result register doubles as the readout hold copy of the last frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_last   <= 1'b0;
         r_out_valid <= 1'b0;
         r_first     <= 1'b1;
         r_acc       <= '0;
         r_hold      <= '0;
         r_beats     <= '0;
         r_out_beats <= '0;
         r_ovf       <= 1'b0;
         r_out_ovf   <= 1'b0;
      end else if (!w_stall) begin
         r_s1_valid  <= in_valid;
         r_s1_last   <= in_valid & in_last;
         r_out_valid <= r_s1_valid & r_s1_last;
         if (r_s1_valid && r_s1_last) begin
            r_hold      <= w_acc_next;
            r_first     <= 1'b1;
            r_out_beats <= w_beats;
            r_beats     <= '0;
            r_out_ovf   <= w_ovf_frame;
            r_ovf       <= 1'b0;
         end else if (r_s1_valid) begin
            r_acc   <= w_acc_next;
            r_first <= 1'b0;
            r_beats <= w_beats;
            r_ovf   <= w_ovf_frame;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rd <= '0;
      else r_rd <= (int'(rd_group) < GROUPS && int'(rd_elem) < BLOCK_ELEMS)
         ? r_hold[(int'(rd_group)*BLOCK_ELEMS + int'(rd_elem))*ACCW +: ACCW] : '0;
   end
   assign out_data  = r_hold;
   assign out_beats = r_out_beats;
   assign out_ovf   = r_out_ovf;
   assign out_valid = r_out_valid;
   assign rd_data   = r_rd;
endmodule

// File: tb/tb_snn_partial_sum_reducer.sv
// tb_snn_partial_sum_reducer: scoreboard bench; expected frame totals are queued as beats
// are accepted and compared when the reducer emits each frame.
module tb_snn_partial_sum_reducer;
   localparam int G  = 3;
   localparam int F  = 3;
   localparam int BE = 16;
   localparam int DW = 32;
   localparam int AW = 40;
   localparam int IW = G * F * BE * DW;
   localparam int OW = G * BE * AW;
   localparam longint MAXV = (longint'(1) << (AW - 1)) - 1;
   localparam longint MINV = -(longint'(1) << (AW - 1));
   typedef struct {
      logic [OW-1:0] data;
      logic [15:0]   beats;
      logic          ovf;
   } exp_t;
   logic          clk = 1'b0, rst_n = 1'b0;
   logic [IW-1:0] in_data = '0;
   logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
   logic          in_ready, out_ovf, out_valid;
   logic [OW-1:0] out_data;
   logic [15:0]   out_beats;
   logic [1:0]    rd_group = '0;
   logic [3:0]    rd_elem = '0;
   logic [AW-1:0] rd_data;
   int            n_vec = 0, n_err = 0, n_frm = 0;
   exp_t          q[$];
   longint        m_acc [G][BE];
   bit            m_first = 1'b1, m_ovf = 1'b0, done = 1'b0;
   int            m_beats = 0;
   snn_partial_sum_reducer dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .out_data(out_data), .out_beats(out_beats), .out_ovf(out_ovf),
      .out_valid(out_valid), .out_ready(out_ready), .rd_group(rd_group), .rd_elem(rd_elem),
      .rd_data(rd_data)
   );
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic longint wrapw(input longint x);
      logic signed [AW-1:0] t;
      t = x[AW-1:0];
      return longint'(t);
   endfunction
   function automatic logic [IW-1:0] fill(input logic [DW-1:0] v);
      logic [IW-1:0] d;
      for (int u = 0; u < G*F*BE; u++) d[u*DW +: DW] = v;
      return d;
   endfunction
   task automatic model_beat(input logic [IW-1:0] d, input logic last);
      exp_t x;
      bit   any;
      int   nb;
      any = 1'b0;
      nb  = (m_beats < 65535) ? m_beats + 1 : 65535;
      for (int g = 0; g < G; g++)
         for (int e = 0; e < BE; e++) begin
            longint s, t;
            logic signed [DW-1:0] v;
            s = 0;
            for (int f = 0; f < F; f++) begin
               v = d[((g*F+f)*BE+e)*DW +: DW];
               s += longint'(v);
            end
            t = (m_first ? 0 : m_acc[g][e]) + s;
`ifdef SNN_REDUCER_SAT_EN
            if (t > MAXV) begin t = MAXV; any = 1'b1; end
            else if (t < MINV) begin t = MINV; any = 1'b1; end
`else
            t = wrapw(t);
`endif
            m_acc[g][e] = t;
         end
      if (last) begin
         for (int g = 0; g < G; g++)
            for (int e = 0; e < BE; e++) x.data[(g*BE+e)*AW +: AW] = m_acc[g][e][AW-1:0];
         x.beats = 16'(nb);
         x.ovf   = m_ovf | any;
         q.push_back(x);
         m_first = 1'b1;
         m_beats = 0;
         m_ovf   = 1'b0;
      end else begin
         m_first = 1'b0;
         m_beats = nb;
         m_ovf   = m_ovf | any;
      end
   endtask
   // Inputs change just after a rising edge; acceptance is decided at the following edge.
   task automatic send(input logic [IW-1:0] d, input logic last);
      int n;
      in_data  = d;
      in_valid = 1'b1;
      in_last  = last;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) chk("in_timeout", 64'(in_ready), 64'd1);
      else model_beat(d, last);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask
   task automatic sync();
      @(posedge clk);
      #1;
   endtask
   task automatic drain();
      int n;
      n = 0;
      while ((q.size() != 0 || out_valid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) chk("drain_timeout", 64'(q.size()), 64'd0);
   endtask
   task automatic rd_chk(input string tag, input logic [1:0] g, input logic [3:0] e, input logic [63:0] exp);
      rd_group = g;
      rd_elem  = e;
      @(posedge clk);
      @(negedge clk);
      chk(tag, 64'(rd_data), exp);
   endtask
   task automatic model_reset();
      m_first = 1'b1;
      m_beats = 0;
      m_ovf   = 1'b0;
   endtask
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         automatic exp_t x;
         if (q.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
         else begin
            x = q.pop_front();
            for (int i = 0; i < G*BE; i++)
               chk($sformatf("f%0d_e%0d", n_frm, i), 64'(out_data[i*AW +: AW]), 64'(x.data[i*AW +: AW]));
            chk($sformatf("f%0d_beats", n_frm), 64'(out_beats), 64'(x.beats));
            chk($sformatf("f%0d_ovf", n_frm), 64'(out_ovf), 64'(x.ovf));
            n_frm++;
         end
      end
   end
   initial begin
      logic [IW-1:0] d;
      int            len;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(|out_data), 64'd0);
      chk("rst_out_beats", 64'(out_beats), 64'd0);
      chk("rst_out_ovf", 64'(out_ovf), 64'd0);
      chk("rst_rd_data", 64'(rd_data), 64'd0);
      sync();
      rst_n = 1'b1;
      sync();
      // four-beat frame of ones: 12 per element, two-cycle latency
      for (int b = 0; b < 4; b++) send(fill(32'd1), b == 3);
      @(negedge clk);
      chk("lat_edge1", 64'(out_valid), 64'd0);
      @(negedge clk);
      chk("lat_edge2", 64'(out_valid), 64'd1);
      drain();
      rd_chk("t1_rd", 2'd1, 4'd15, 64'd12);
      rd_chk("rd_oob", 2'd3, 4'd0, 64'd0);
      sync();
      // group 0 elements 1..16, others zero
      d = '0;
      for (int f = 0; f < F; f++)
         for (int e = 0; e < BE; e++) d[(f*BE+e)*DW +: DW] = DW'(e + 1);
      send(d, 1'b1);
      drain();
      rd_chk("t2_rd_g0e5", 2'd0, 4'd5, 64'd18);
      rd_chk("t2_rd_g2e5", 2'd2, 4'd5, 64'd0);
      sync();
      // backpressure: two results while out_ready is low, third beat must wait
      out_ready = 1'b0;
      send(fill(32'd2), 1'b1);
      send(fill(32'd3), 1'b1);
      fork
         send(fill(32'd4), 1'b1);
         begin
            repeat (5) begin
               @(negedge clk);
               chk("stall_in_ready", 64'(in_ready), 64'd0);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      sync();
      // negative elements
      for (int b = 0; b < 3; b++) send(fill(32'hFFFF_FFFF), b == 2);
      drain();
      rd_chk("neg_rd", 2'd0, 4'd0, 64'(40'hFF_FFFF_FFF7));
      sync();
      // in_last without in_valid is ignored
      send(fill(32'd1), 1'b0);
      in_last = 1'b1;
      sync();
      in_last = 1'b0;
      send(fill(32'd1), 1'b1);
      drain();
      sync();
      // reset in the middle of a frame discards the partial total
      send(fill(32'd5), 1'b0);
      send(fill(32'd5), 1'b0);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      chk("mid_rst_rd", 64'(rd_data), 64'd0);
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      sync();
      rst_n = 1'b1;
      sync();
      send(fill(32'd1), 1'b1);
      drain();
      rd_chk("post_rst_rd", 2'd2, 4'd3, 64'd3);
      sync();
      // long frame of maximum positive values crosses the accumulator range
      for (int b = 0; b < 90; b++) send(fill(32'h7FFF_FFFF), b == 89);
      drain();
      sync();
      // random frames with random output backpressure
      fork
         begin
            for (int fr = 0; fr < 20; fr++) begin
               len = $urandom_range(1, 4);
               for (int b = 0; b < len; b++) begin
                  for (int w = 0; w < IW/32; w++) d[w*32 +: 32] = $urandom();
                  send(d, b == len - 1);
               end
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain();
      chk("frames_left", 64'(q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
